// File: rtl/spike_event_encoder.sv
// Threshold-crossing spike detector for the time-multiplexed neuron stream.
// Crossing events {timestep, neuron_id} are buffered in a FIFO drained by valid/ready.
module spike_event_encoder #(
    parameter int                           neuron_count = 500,
    parameter int                           data_width   = 16,
    parameter logic signed [data_width-1:0] V_THRESH     = 16'sh1E00,
    parameter int                           TS_W         = 16,
    parameter int                           FIFO_DEPTH   = 16,
    parameter int                           DROP_W       = 8,
    localparam int                          ID_W         = $clog2(neuron_count)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [ID_W-1:0]              in_id,
    input  logic signed [data_width-1:0] in_v,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ID_W-1:0]              out_id,
    output logic [TS_W-1:0]              out_ts,
    output logic                         step_done,
    output logic [TS_W-1:0]              timestep,
    output logic                         overflow,
    output logic [DROP_W-1:0]            drop_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [neuron_count-1:0] above_q, above_d;
    logic                    accept, is_above, spike, last_id;

    logic                    s1_valid_q;
    logic [ID_W-1:0]         s1_id_q;
    logic [TS_W-1:0]         s1_ts_q;

    logic [TS_W-1:0]         ts_q, ts_d;
    logic                    step_done_q;

    logic [ID_W-1:0]         mem_id [FIFO_DEPTH];
    logic [TS_W-1:0]         mem_ts [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    full, push, pop, drop;
    logic [DROP_W-1:0]       drop_q, drop_d;
    logic                    overflow_q, overflow_d;

    assign accept   = in_valid && (32'(in_id) < neuron_count);
    assign is_above = in_v >= V_THRESH;
    assign spike    = accept && is_above && !above_q[in_id];
    assign last_id  = accept && (32'(in_id) == neuron_count - 1);

    always_comb begin
        above_d = above_q;
        if (accept) above_d[in_id] = is_above;
    end

    assign ts_d = last_id ? ts_q + TS_W'(1) : ts_q;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign full = (cnt_q == CNT_W'(FIFO_DEPTH));
    assign pop  = out_valid && out_ready;
    assign push = s1_valid_q && (!full || pop);
    assign drop = s1_valid_q && full && !pop;

    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        cnt_d      = cnt_q;
        if (push && !pop) cnt_d = cnt_q + CNT_W'(1);
        if (pop && !push) cnt_d = cnt_q - CNT_W'(1);
        drop_d     = drop_q;
        if (drop && (drop_q != {DROP_W{1'b1}})) drop_d = drop_q + DROP_W'(1);
        overflow_d = overflow_q || drop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            above_q     <= '0;
            s1_valid_q  <= 1'b0;
            s1_id_q     <= '0;
            s1_ts_q     <= '0;
            ts_q        <= '0;
            step_done_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            drop_q      <= '0;
            overflow_q  <= 1'b0;
        end else begin
            above_q     <= above_d;
            s1_valid_q  <= spike;
            if (accept) begin
                s1_id_q <= in_id;
                s1_ts_q <= ts_q;
            end
            ts_q        <= ts_d;
            step_done_q <= last_id;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            drop_q      <= drop_d;
            overflow_q  <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_id[wr_ptr_q] <= s1_id_q;
            mem_ts[wr_ptr_q] <= s1_ts_q;
        end
    end

    // Head is forced to zero when empty so stale storage never leaks out.
    assign out_valid  = (cnt_q != '0);
    assign out_id     = out_valid ? mem_id[rd_ptr_q] : '0;
    assign out_ts     = out_valid ? mem_ts[rd_ptr_q] : '0;
    assign step_done  = step_done_q;
    assign timestep   = ts_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_spike_event_encoder.sv
// Directed bench for spike_event_encoder: vector table for crossing/timestep
// behaviour plus hand sequences for overflow, saturation and reset.
module tb_spike_event_encoder;

    localparam int ID_W = 9;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic [ID_W-1:0]    in_id;
    logic signed [15:0] in_v;
    logic               out_valid;
    logic               out_ready;
    logic [ID_W-1:0]    out_id;
    logic [15:0]        out_ts;
    logic               step_done;
    logic [15:0]        timestep;
    logic               overflow;
    logic [7:0]         drop_count;

    int checks = 0;
    int errors = 0;

    spike_event_encoder dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_id      (in_id),
        .in_v       (in_v),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_id     (out_id),
        .out_ts     (out_ts),
        .step_done  (step_done),
        .timestep   (timestep),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        int          id;
        logic [15:0] v;
        logic        rdy;
        logic        e_valid;
        int          e_id;
        int          e_ts;
        logic        e_step;
        int          e_timestep;
    } vec_t;

    vec_t tbl [24];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the edge, outputs are read at that same point.
    task automatic cyc(input logic v, input int id, input logic [15:0] val, input logic rdy);
        in_valid  = v;
        in_id     = ID_W'(id);
        in_v      = val;
        out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_id"}, 32'(out_id), 32'd0);
        chk({tag, "_out_ts"}, 32'(out_ts), 32'd0);
        chk({tag, "_timestep"}, 32'(timestep), 32'd0);
        chk({tag, "_step_done"}, 32'(step_done), 32'd0);
        chk({tag, "_drop_count"}, 32'(drop_count), 32'd0);
        chk({tag, "_overflow"}, 32'(overflow), 32'd0);
    endtask

    int exp_q [$];

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_id = '0; in_v = '0; out_ready = 1'b0;

        tbl[0]  = '{1'b1,   7, 16'h1000, 1'b1, 1'b0, 0, 0, 1'b0, 1};
        tbl[1]  = '{1'b1, 499, 16'h0000, 1'b1, 1'b0, 0, 0, 1'b1, 2};
        tbl[2]  = '{1'b1, 499, 16'h0000, 1'b1, 1'b0, 0, 0, 1'b1, 3};
        tbl[3]  = '{1'b1,   7, 16'h1E00, 1'b1, 1'b0, 0, 0, 1'b0, 3};
        tbl[4]  = '{1'b0,   0, 16'h0000, 1'b0, 1'b1, 7, 3, 1'b0, 3};
        tbl[5]  = '{1'b0,   0, 16'h0000, 1'b0, 1'b1, 7, 3, 1'b0, 3};
        tbl[6]  = '{1'b0,   0, 16'h0000, 1'b1, 1'b0, 0, 0, 1'b0, 3};
        tbl[7]  = '{1'b1, 499, 16'h0000, 1'b1, 1'b0, 0, 0, 1'b1, 4};
        tbl[8]  = '{1'b1,   7, 16'h2000, 1'b1, 1'b0, 0, 0, 1'b0, 4};
        tbl[9]  = '{1'b0,   0, 16'h0000, 1'b1, 1'b0, 0, 0, 1'b0, 4};
        tbl[10] = '{1'b1, 499, 16'h0000, 1'b1, 1'b0, 0, 0, 1'b1, 5};
        tbl[11] = '{1'b1,   7, 16'h1000, 1'b1, 1'b0, 0, 0, 1'b0, 5};
        tbl[12] = '{1'b1, 499, 16'h0000, 1'b1, 1'b0, 0, 0, 1'b1, 6};
        tbl[13] = '{1'b1,   7, 16'h1E00, 1'b1, 1'b0, 0, 0, 1'b0, 6};
        tbl[14] = '{1'b0,   0, 16'h0000, 1'b0, 1'b1, 7, 6, 1'b0, 6};
        tbl[15] = '{1'b0,   0, 16'h0000, 1'b1, 1'b0, 0, 0, 1'b0, 6};
        tbl[16] = '{1'b1,   8, 16'h8000, 1'b1, 1'b0, 0, 0, 1'b0, 6};
        tbl[17] = '{1'b1,   9, 16'h1DFF, 1'b1, 1'b0, 0, 0, 1'b0, 6};
        tbl[18] = '{1'b0,   0, 16'h0000, 1'b1, 1'b0, 0, 0, 1'b0, 6};
        tbl[19] = '{1'b1, 510, 16'h7FFF, 1'b1, 1'b0, 0, 0, 1'b0, 6};
        tbl[20] = '{1'b0,   0, 16'h0000, 1'b1, 1'b0, 0, 0, 1'b0, 6};
        tbl[21] = '{1'b1,   9, 16'h1E00, 1'b1, 1'b0, 0, 0, 1'b0, 6};
        tbl[22] = '{1'b0,   0, 16'h0000, 1'b0, 1'b1, 9, 6, 1'b0, 6};
        tbl[23] = '{1'b0,   0, 16'h0000, 1'b1, 1'b0, 0, 0, 1'b0, 6};

        cyc(1'b0, 0, 16'h0, 1'b0);
        cyc(1'b0, 0, 16'h0, 1'b0);
        chk_reset_state("por");
        rst = 1'b0;

        // Full sweep with everything below threshold
        for (int i = 0; i < 500; i++) begin
            cyc(1'b1, i, -16'sd4895, 1'b1);
            chk("sweep_out_valid", 32'(out_valid), 32'd0);
            chk("sweep_step_done", 32'(step_done), (i == 499) ? 32'd1 : 32'd0);
        end
        chk("sweep_timestep", 32'(timestep), 32'd1);
        cyc(1'b0, 0, 16'h0, 1'b1);
        chk("sweep_step_done_after", 32'(step_done), 32'd0);
        chk("sweep_out_valid_after", 32'(out_valid), 32'd0);

        for (int i = 0; i < 24; i++) begin
            cyc(tbl[i].vld, tbl[i].id, tbl[i].v, tbl[i].rdy);
            chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_valid));
            chk($sformatf("vec%0d_step_done", i), 32'(step_done), 32'(tbl[i].e_step));
            chk($sformatf("vec%0d_timestep", i), 32'(timestep), 32'(tbl[i].e_timestep));
            if (tbl[i].e_valid) begin
                chk($sformatf("vec%0d_out_id", i), 32'(out_id), 32'(tbl[i].e_id));
                chk($sformatf("vec%0d_out_ts", i), 32'(out_ts), 32'(tbl[i].e_ts));
            end
        end

        // 20 crossings into a stalled FIFO: 16 kept, 4 dropped
        for (int k = 0; k < 20; k++) cyc(1'b1, 20 + k, 16'h1E00, 1'b0);
        cyc(1'b0, 0, 16'h0, 1'b0);
        cyc(1'b0, 0, 16'h0, 1'b0);
        chk("ovf_out_valid", 32'(out_valid), 32'd1);
        chk("ovf_head_id", 32'(out_id), 32'd20);
        chk("ovf_head_ts", 32'(out_ts), 32'd6);
        chk("ovf_drop_count", 32'(drop_count), 32'd4);
        chk("ovf_overflow", 32'(overflow), 32'd1);
        cyc(1'b0, 0, 16'h0, 1'b0);
        chk("ovf_hold_id", 32'(out_id), 32'd20);
        chk("ovf_hold_ts", 32'(out_ts), 32'd6);

        // Crossing lands on a full FIFO in the same cycle as a pop
        cyc(1'b1, 40, 16'h1E00, 1'b0);
        chk("fullpop_pre_id", 32'(out_id), 32'd20);
        cyc(1'b0, 0, 16'h0, 1'b1);
        chk("fullpop_drop_count", 32'(drop_count), 32'd4);
        exp_q.delete();
        for (int k = 21; k <= 35; k++) exp_q.push_back(k);
        exp_q.push_back(40);
        foreach (exp_q[j]) begin
            chk($sformatf("drain%0d_valid", j), 32'(out_valid), 32'd1);
            chk($sformatf("drain%0d_id", j), 32'(out_id), 32'(exp_q[j]));
            chk($sformatf("drain%0d_ts", j), 32'(out_ts), 32'd6);
            cyc(1'b0, 0, 16'h0, 1'b1);
        end
        chk("drain_empty", 32'(out_valid), 32'd0);
        chk("drain_drop_count", 32'(drop_count), 32'd4);

        // Drop counter growth and saturation
        for (int n = 1; n <= 300; n++) begin
            cyc(1'b1, 50, 16'h1E00, 1'b0);
            cyc(1'b1, 50, 16'h0000, 1'b0);
            if (n == 100) chk("drop_mid", 32'(drop_count), 32'd88);
        end
        cyc(1'b0, 0, 16'h0, 1'b0);
        chk("drop_saturated", 32'(drop_count), 32'd255);
        chk("drop_overflow", 32'(overflow), 32'd1);
        chk("drop_out_valid", 32'(out_valid), 32'd1);

        rst = 1'b1;
        cyc(1'b0, 0, 16'h0, 1'b0);
        rst = 1'b0;
        chk_reset_state("rst1");

        // Reset with queued events and a spike in flight
        cyc(1'b1, 499, 16'h0, 1'b0);
        cyc(1'b1, 499, 16'h0, 1'b0);
        chk("pre_rst_timestep", 32'(timestep), 32'd2);
        cyc(1'b1, 70, 16'h1E00, 1'b0);
        for (int k = 60; k <= 63; k++) cyc(1'b1, k, 16'h1E00, 1'b0);
        cyc(1'b1, 65, 16'h1E00, 1'b0);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        chk("pre_rst_id", 32'(out_id), 32'd70);
        chk("pre_rst_ts", 32'(out_ts), 32'd2);
        rst = 1'b1;
        cyc(1'b1, 499, 16'h0, 1'b1);
        rst = 1'b0;
        chk_reset_state("rst2");
        cyc(1'b0, 0, 16'h0, 1'b0);
        cyc(1'b0, 0, 16'h0, 1'b0);
        chk("post_rst_no_inflight", 32'(out_valid), 32'd0);
        cyc(1'b1, 70, 16'h1E00, 1'b0);
        cyc(1'b0, 0, 16'h0, 1'b0);
        chk("post_rst_respike_valid", 32'(out_valid), 32'd1);
        chk("post_rst_respike_id", 32'(out_id), 32'd70);
        chk("post_rst_respike_ts", 32'(out_ts), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
